branch_target_buffer: RTL and testbench

Two-way set-associative branch target buffer in the IF stage, alongside the branch direction predictor. Each cycle it looks up the fetch PC and supplies a hit flag plus the cached taken-target, so fetch can redirect on a predicted-taken branch without waiting for decode. It is trained from write-back with the resolved targets of valid taken branches. It also keeps saturating lookup/hit counters for performance analysis.

---
 rtl/branch_target_buffer.sv | 105 ++++++++++
 tb/tb_branch_target_buffer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/branch_target_buffer.sv
// Two-way set-associative branch target buffer for the IF stage: combinational lookup
// of the fetch PC, training from write-back, and saturating lookup/hit counters.
module branch_target_buffer #(
  parameter int set_bits  = 3,
  parameter int cnt_width = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [15:0]          PC_if,
  input  logic                 lookup_valid,
  input  logic [15:0]          PC_wb,
  input  logic [15:0]          target_wb,
  input  logic                 update,
  input  logic                 enable,
  input  logic                 flush,
  output logic                 btb_hit,
  output logic [15:0]          btb_target,
  output logic [cnt_width-1:0] lookup_count,
  output logic [cnt_width-1:0] hit_count
);

  localparam int sets  = 1 << set_bits;
  localparam int tag_w = 15 - set_bits;

  typedef logic [set_bits-1:0] idx_t;
  typedef logic [tag_w-1:0]    tag_t;

  logic [sets-1:0][1:0] valid;
  logic [sets-1:0]      lru;         // names the least-recently-written way
  tag_t                 tag_mem    [sets][2];
  logic [15:0]          target_mem [sets][2];

  // The PC is word aligned, so bit 0 carries no information.
  logic unused_pc_lsb;
  assign unused_pc_lsb = PC_if[0] ^ PC_wb[0];

  idx_t idx_if, idx_wb;
  tag_t tag_if, tag_wb;
  assign idx_if = PC_if[set_bits:1];
  assign tag_if = PC_if[15:set_bits+1];
  assign idx_wb = PC_wb[set_bits:1];
  assign tag_wb = PC_wb[15:set_bits+1];

  logic [1:0] hit_if, hit_wb;
  logic       way_wb;
  logic       do_write;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    hit_if = '0;
    hit_wb = '0;
    for (int w = 0; w < 2; w++) begin
      hit_if[w] = valid[idx_if][w] && (tag_mem[idx_if][w] == tag_if);
      hit_wb[w] = valid[idx_wb][w] && (tag_mem[idx_wb][w] == tag_wb);
    end
  end

  assign btb_hit    = |hit_if;
  assign btb_target = hit_if[0] ? target_mem[idx_if][0] :
                      hit_if[1] ? target_mem[idx_if][1] : 16'h0000;

  // Retarget a matching way; else fill an invalid way (way 0 first); else evict LRU.
  always_comb begin
    way_wb = lru[idx_wb];
    if (hit_wb[0])             way_wb = 1'b0;
    else if (hit_wb[1])        way_wb = 1'b1;
    else if (!valid[idx_wb][0]) way_wb = 1'b0;
    else if (!valid[idx_wb][1]) way_wb = 1'b1;
  end

  assign do_write = update && enable && !flush;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= '0;
      lru   <= '0;
    end else if (flush) begin
      valid <= '0;
      lru   <= '0;
    end else if (do_write) begin
      valid[idx_wb][way_wb] <= 1'b1;
      lru[idx_wb]           <= ~way_wb;
    end
  end

  // NOTE: tag/target arrays are deliberately not reset; valid bits gate every use of them.
  always_ff @(posedge clk) begin
    if (do_write) begin
      tag_mem[idx_wb][way_wb]    <= tag_wb;
      target_mem[idx_wb][way_wb] <= target_wb;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lookup_count <= '0;
      hit_count    <= '0;
    end else if (enable && lookup_valid) begin
      if (lookup_count != '1) lookup_count <= lookup_count + cnt_width'(1);
      if (btb_hit && hit_count != '1) hit_count <= hit_count + cnt_width'(1);
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: each set is modelled as a recency-ordered
// list of at most two {pc, target} entries; a negedge monitor compares DUT outputs.
module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] PC_if = '0, PC_wb = '0, target_wb = '0;
  logic        lookup_valid = 1'b0, update = 1'b0, enable = 1'b0, flush = 1'b0;
  logic        btb_hit;
  logic [15:0] btb_target, lookup_count, hit_count;

  branch_target_buffer dut (
    .clk(clk), .reset(reset), .PC_if(PC_if), .lookup_valid(lookup_valid),
    .PC_wb(PC_wb), .target_wb(target_wb), .update(update), .enable(enable),
    .flush(flush), .btb_hit(btb_hit), .btb_target(btb_target),
    .lookup_count(lookup_count), .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] want);
    checks++;
    if (actual !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, actual, want, $time);
    end
  endtask

  // Reference model: entries keyed by PC[15:1]; back of each queue = most recently written.
  typedef struct { logic [14:0] key; logic [15:0] tgt; } ent_t;
  ent_t set_q [8][$];
  int   m_lc, m_hc;

  typedef struct { logic hit; logic [15:0] tgt; logic [15:0] lc; logic [15:0] hc; } exp_t;
  exp_t sb[$];

  function automatic void model_clear();
    for (int s = 0; s < 8; s++) set_q[s].delete();
  endfunction

  function automatic void model_lookup(input logic [15:0] pc, output logic hit, output logic [15:0] tgt);
    logic [14:0] k = pc[15:1];
    hit = 1'b0;
    tgt = 16'h0000;
    foreach (set_q[k[2:0]][i])
      if (set_q[k[2:0]][i].key == k) begin
        hit = 1'b1;
        tgt = set_q[k[2:0]][i].tgt;
      end
  endfunction

  function automatic void model_write(input logic [15:0] pc, input logic [15:0] tgt);
    logic [14:0] k = pc[15:1];
    int s = int'(k[2:0]);
    for (int i = 0; i < set_q[s].size(); i++)
      if (set_q[s][i].key == k) begin
        set_q[s].delete(i);
        break;
      end
    if (set_q[s].size() == 2) void'(set_q[s].pop_front());
    set_q[s].push_back('{key: k, tgt: tgt});
  endfunction

  // One clock cycle: drive inputs, queue the expected response, advance the model at the edge.
  task automatic cycle(input logic [15:0] pc, input logic lv, input logic [15:0] pcw,
                       input logic [15:0] tw, input logic upd, input logic en, input logic fl);
    logic        h;
    logic [15:0] t;
    PC_if = pc; lookup_valid = lv; PC_wb = pcw; target_wb = tw;
    update = upd; enable = en; flush = fl;
    model_lookup(pc, h, t);
    sb.push_back('{hit: h, tgt: t, lc: 16'(m_lc), hc: 16'(m_hc)});
    @(posedge clk);
    if (en && lv) begin
      if (m_lc < 65535) m_lc++;
      if (h && m_hc < 65535) m_hc++;
    end
    if (fl) model_clear();
    else if (upd && en) model_write(pcw, tw);
    #1;
  endtask

  task automatic look(input logic [15:0] pc);
    cycle(pc, 1'b1, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic train(input logic [15:0] pc, input logic [15:0] tgt);
    cycle(16'h0000, 1'b0, pc, tgt, 1'b1, 1'b1, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("btb_hit", 32'(btb_hit), 32'(e.hit));
      check("btb_target", 32'(btb_target), 32'(e.tgt));
      check("lookup_count", 32'(lookup_count), 32'(e.lc));
      check("hit_count", 32'(hit_count), 32'(e.hc));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        h;
    logic [15:0] t;
    model_clear();
    m_lc = 0;
    m_hc = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Reset state, then update-then-hit with read-before-write.
    look(16'h3000);
    look(16'h3000);
    cycle(16'h3004, 1'b1, 16'h3004, 16'h3100, 1'b1, 1'b1, 1'b0);
    look(16'h3004);

    // Conflict replacement within set 2.
    train(16'h3014, 16'h3200);
    train(16'h3024, 16'h3300);
    look(16'h3004); look(16'h3014); look(16'h3024);

    // Retarget an existing entry, no duplicate, then LRU-directed eviction.
    cycle(16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1);
    train(16'h3004, 16'h3100);
    train(16'h3004, 16'h3180);
    look(16'h3004);
    train(16'h3014, 16'h3200);
    look(16'h3004); look(16'h3014);
    train(16'h3024, 16'h3300);
    look(16'h3004); look(16'h3014); look(16'h3024);

    // Flush beats a same-cycle update; disabled update is dropped.
    train(16'h3050, 16'h3600);
    cycle(16'h3050, 1'b1, 16'h3040, 16'h3500, 1'b1, 1'b1, 1'b1);
    look(16'h3040); look(16'h3050); look(16'h3014); look(16'h3024);
    cycle(16'h0, 1'b1, 16'h3060, 16'h3700, 1'b1, 1'b0, 1'b0);
    look(16'h3060);

    // Randomized traffic over a small pool of conflicting PCs (bit 0 sometimes set).
    for (int n = 0; n < 600; n++) begin
      logic [15:0] pa, pb;
      pa = 16'h3000 + 16'($urandom_range(0, 3) << 4) + 16'($urandom_range(0, 3) << 1)
           + 16'($urandom_range(0, 1));
      pb = 16'h3000 + 16'($urandom_range(0, 3) << 4) + 16'($urandom_range(0, 3) << 1)
           + 16'($urandom_range(0, 1));
      cycle(pa, 1'($urandom_range(0, 3) != 0), pb, 16'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0),
            1'($urandom_range(0, 39) == 0));
    end

    // Saturation: enough qualified hitting lookups to pin both counters at all-ones.
    train(16'h3004, 16'h3100);
    for (int n = 0; n < 65538; n++) look(16'h3004);
    look(16'h3004);
    check("lookup_count_sat", 32'(lookup_count), 32'h0000_FFFF);
    check("hit_count_sat", 32'(hit_count), 32'h0000_FFFF);

    // Asynchronous reset mid-cycle clears counters and the hit immediately.
    PC_if = 16'h3004; lookup_valid = 1'b1; update = 1'b0;
    #1;
    model_lookup(16'h3004, h, t);
    check("pre_reset_hit", 32'(btb_hit), 32'(h));
    reset = 1'b0;
    #1;
    check("async_reset_hit", 32'(btb_hit), 32'h0);
    check("async_reset_target", 32'(btb_target), 32'h0);
    check("async_reset_lookup_count", 32'(lookup_count), 32'h0);
    check("async_reset_hit_count", 32'(hit_count), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
